// File: rtl/mips_muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the
// multiply/divide unit that owns the HI/LO pair.
package mips_muldiv_pkg;

    typedef logic [3:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t MULT  = 4'd0;
    localparam op_t MULTU = 4'd1;
    localparam op_t MADD  = 4'd2;
    localparam op_t MADDU = 4'd3;
    localparam op_t MSUB  = 4'd4;
    localparam op_t MSUBU = 4'd5;
    localparam op_t DIV   = 4'd6;
    localparam op_t DIVU  = 4'd7;
    localparam op_t MUL   = 4'd8;
    localparam op_t MTHI  = 4'd9;
    localparam op_t MTLO  = 4'd10;

    localparam state_t IDLE = 2'd0;
    localparam state_t MRUN = 2'd1;
    localparam state_t DRUN = 2'd2;
    localparam state_t FIX  = 2'd3;

    function automatic logic is_signed(input op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
    endfunction

    function automatic logic is_accum(input op_t op);
        return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/mips_muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per enabled cycle, on unsigned magnitudes.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic             borrow;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply adds into the upper half; divide shifts the next dividend
    // bit into the partial remainder and trial-subtracts the divisor.
    always_comb begin
        add_sum          = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, d};
        rem_shift        = p[2*WIDTH-1:WIDTH-1];
        {borrow, diff}   = {1'b0, rem_shift[WIDTH-1:0]} - {1'b0, d};
        fits             = rem_shift[WIDTH] | ~borrow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
            d <= '0;
        end else if (load) begin
            p <= {{WIDTH{1'b0}}, a};
            d <= b;
        end else if (step) begin
            if (div_mode)
                p <= fits ? {diff, p[WIDTH-2:0], 1'b1}
                          : {rem_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
            else
                p <= p[0] ? {add_sum, p[WIDTH-1:1]}
                          : {1'b0, p[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: FSM, iteration counter,
// sign fix-up and result write-back around the shared iterative core.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit DIV0_KEEP = 1'b1
) (
    input  logic             muu_clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mul_result
);

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t             state;
    op_t                op_q;
    logic [5:0]         cnt;
    logic               res_neg;
    logic               rem_neg;
    logic               div0;
    logic [2*WIDTH-1:0] p;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] hilo_next;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   dvd_fix;

    assign busy = (state != IDLE);

    // Operands go to the core as magnitudes; signs are restored in FIX.
    always_comb begin
        a_neg = is_signed(op) & rs_val[WIDTH-1];
        b_neg = is_signed(op) & rt_val[WIDTH-1];
        mag_a = a_neg ? -rs_val : rs_val;
        mag_b = b_neg ? -rt_val : rt_val;
    end

    always_comb begin
        prod_fix = res_neg ? -p : p;
        if (!is_accum(op_q))
            hilo_next = prod_fix;
        else if (op_q == MSUB || op_q == MSUBU)
            hilo_next = {hi, lo} - prod_fix;
        else
            hilo_next = {hi, lo} + prod_fix;
        quot_fix = res_neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem_fix  = rem_neg ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        dvd_fix  = rem_neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (muu_clock),
        .reset    (reset),
        .load     ((state == IDLE) && start),
        .step     ((state == MRUN) || (state == DRUN)),
        .div_mode (state == DRUN),
        .a        (mag_a),
        .b        (mag_b),
        .p        (p)
    );

    always_ff @(posedge muu_clock) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= MULT;
            cnt        <= '0;
            res_neg    <= 1'b0;
            rem_neg    <= 1'b0;
            div0       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            mul_result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q    <= op;
                    cnt     <= '0;
                    res_neg <= a_neg ^ b_neg;
                    rem_neg <= a_neg;
                    div0    <= 1'b0;
                    case (op)
                        MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL:
                            state <= MRUN;
                        DIV, DIVU: begin
                            if (rt_val == '0) begin
                                div0  <= 1'b1;
                                state <= FIX;
                            end else begin
                                state <= DRUN;
                            end
                        end
                        MTHI: begin
                            hi   <= rs_val;
                            done <= 1'b1;
                        end
                        MTLO: begin
                            lo   <= rs_val;
                            done <= 1'b1;
                        end
                        default: done <= 1'b1;
                    endcase
                end
                MRUN, DRUN: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                default: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (op_q == DIV || op_q == DIVU) begin
                        if (!div0) begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end else if (!DIV0_KEEP) begin
                            lo <= '1;
                            hi <= dvd_fix;
                        end
                    end else if (op_q == MUL) begin
                        mul_result <= prod_fix[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= hilo_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed scoreboard bench for mips_muldiv_unit: a 32-bit instance for the
// main op sequence and an 8-bit instance for the narrow-width rerun.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [3:0]  op, op8;
    logic [31:0] rs_val, rt_val;
    logic [7:0]  rs8, rt8;
    logic        busy, done, busy8, done8;
    logic [31:0] hi, lo, mul_result;
    logic [7:0]  hi8, lo8, mul_result8;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32), .DIV0_KEEP(1'b1)) dut (
        .muu_clock (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .mul_result(mul_result)
    );

    mips_muldiv_unit #(.WIDTH(8), .DIV0_KEEP(1'b1)) dut8 (
        .muu_clock (clk),
        .reset     (reset),
        .start     (start8),
        .op        (op8),
        .rs_val    (rs8),
        .rt_val    (rt8),
        .busy      (busy8),
        .done      (done8),
        .hi        (hi8),
        .lo        (lo8),
        .mul_result(mul_result8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drives one op, waits (bounded) for done, then pops and checks the
    // expected result; poke injects a stray mthi start mid-operation.
    task automatic applyStimulus(input string tag, input bit use8, input logic [3:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ehi, input logic [31:0] elo,
                                 input logic [31:0] emr, input int elat, input bit poke);
        exp_t e;
        int   lat;
        int   extra;
        logic busy_mid;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.mr = emr; e.lat = elat;
        sb.push_back(e);
        busy_mid = 1'b0;
        @(negedge clk);
        if (use8) begin
            start8 = 1'b1; op8 = o; rs8 = a[7:0]; rt8 = b[7:0];
        end else begin
            start = 1'b1; op = o; rs_val = a; rt_val = b;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start8 = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!(use8 ? done8 : done) && lat < 200) begin
            if (lat == 1) busy_mid = use8 ? busy8 : busy;
            if (poke && lat == 5) begin
                start = 1'b1; op = MTHI; rs_val = 32'hdeadbeef;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        checkOutput({e.tag, " latency"}, 32'(lat), 32'(e.lat));
        if (use8) begin
            checkOutput({e.tag, " hi"}, {24'b0, hi8}, e.hi);
            checkOutput({e.tag, " lo"}, {24'b0, lo8}, e.lo);
            checkOutput({e.tag, " mul_result"}, {24'b0, mul_result8}, e.mr);
            checkOutput({e.tag, " busy at done"}, {31'b0, busy8}, 32'd0);
        end else begin
            checkOutput({e.tag, " hi"}, hi, e.hi);
            checkOutput({e.tag, " lo"}, lo, e.lo);
            checkOutput({e.tag, " mul_result"}, mul_result, e.mr);
            checkOutput({e.tag, " busy at done"}, {31'b0, busy}, 32'd0);
        end
        if (e.lat > 1)
            checkOutput({e.tag, " busy mid-op"}, {31'b0, busy_mid}, 32'd1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (use8 ? done8 : done) extra++;
        end
        checkOutput({e.tag, " extra done"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int extra;
        reset = 1'b1; start = 1'b0; start8 = 1'b0;
        op = MULT; op8 = MULT; rs_val = '0; rt_val = '0; rs8 = '0; rt8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset mul_result", mul_result, 32'd0);

        applyStimulus("mult", 0, MULT, 32'hfffffffe, 32'h0000000e, 32'hffffffff, 32'hffffffe4, 32'd0, 33, 0);
        applyStimulus("unknown op", 0, 4'hf, 32'h12345678, 32'h9, 32'hffffffff, 32'hffffffe4, 32'd0, 0, 0);
        applyStimulus("mtlo", 0, MTLO, 32'h5, 32'h0, 32'hffffffff, 32'h5, 32'd0, 0, 0);
        applyStimulus("mthi", 0, MTHI, 32'h0, 32'h0, 32'h0, 32'h5, 32'd0, 0, 0);
        applyStimulus("madd", 0, MADD, 32'h3, 32'h4, 32'h0, 32'h11, 32'd0, 33, 0);
        applyStimulus("msubu to zero", 0, MSUBU, 32'h11, 32'h1, 32'h0, 32'h0, 32'd0, 33, 0);
        applyStimulus("msubu wrap", 0, MSUBU, 32'h1, 32'h1, 32'hffffffff, 32'hffffffff, 32'd0, 33, 0);
        applyStimulus("div neg", 0, DIV, 32'hfffffff9, 32'h2, 32'hffffffff, 32'hfffffffd, 32'd0, 33, 0);
        applyStimulus("divu", 0, DIVU, 32'h7, 32'h2, 32'h1, 32'h3, 32'd0, 33, 0);
        applyStimulus("div overflow", 0, DIV, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000, 32'd0, 33, 0);
        applyStimulus("clear lo", 0, MTLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 0, 0);
        applyStimulus("div by zero", 0, DIV, 32'hfffffffe, 32'h0, 32'h0, 32'h0, 32'd0, 1, 0);
        applyStimulus("mul", 0, MUL, 32'hfffffffe, 32'h0000000e, 32'h0, 32'h0, 32'hffffffe4, 33, 1);
        applyStimulus("preload lo", 0, MTLO, 32'h1234, 32'h0, 32'h0, 32'h1234, 32'hffffffe4, 0, 0);
        applyStimulus("preload hi", 0, MTHI, 32'habcd, 32'h0, 32'habcd, 32'h1234, 32'hffffffe4, 0, 0);

        // Abort a mult after ten iterations; nothing may be written back.
        @(negedge clk);
        start = 1'b1; op = MULT; rs_val = 32'h7; rt_val = 32'h9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        checkOutput("abort done", {31'b0, done}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        checkOutput("abort mul_result", mul_result, 32'd0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        checkOutput("abort no done", 32'(extra), 32'd0);

        applyStimulus("w8 mult", 1, MULT, 32'hfe, 32'h0e, 32'hff, 32'he4, 32'd0, 9, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
